// File: rtl/dma_calc_sequencer.sv
// dma_calc_sequencer: splits one DMA job into AR and AW bursts, bounds outstanding bursts per side
// and pulses done once every burst has completed. Define DMA_CALC_SEQ_4K_SPLIT_EN to keep bursts inside 4 KB pages.

module dma_calc_side #(
    parameter int unsigned ADDR_BITS  = 40,
    parameter int unsigned LEN_BITS   = 32,
    parameter int unsigned BURST_BITS = 8,
    parameter int unsigned BYTE_SIZE  = 4,
    parameter int unsigned MAX_ISSUE  = 8,
    localparam int unsigned CNT_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  run,
    input  logic [ADDR_BITS-1:0]  base,
    input  logic [LEN_BITS-1:0]   len,
    input  logic                  cmd_ready,
    input  logic                  burst_done,
    output logic [ADDR_BITS-1:0]  cmd_addr,
    output logic [BURST_BITS-1:0] cmd_len,
    output logic                  cmd_valid,
    output logic [CNT_BITS-1:0]   cnt,
    output logic [CNT_BITS-1:0]   cnt_nxt_c,
    output logic                  rem_zero_c,
    output logic                  err_c
);
    localparam int unsigned PAGE_BITS = 13;
    localparam logic [LEN_BITS-1:0] MAX_BEATS = LEN_BITS'(1) << BURST_BITS;

    logic [ADDR_BITS-1:0] addr_q;
    logic [LEN_BITS-1:0]  rem_q;
    logic [LEN_BITS-1:0]  beats_q;
    logic [LEN_BITS-1:0]  beats_c;
    logic                 fire;
`ifdef DMA_CALC_SEQ_4K_SPLIT_EN
    logic [PAGE_BITS-1:0] page_bytes_c;
    logic [LEN_BITS-1:0]  page_beats_c;
`endif

    assign fire       = cmd_valid & cmd_ready;
    assign rem_zero_c = (rem_q == '0);

    // Beats of the next burst: min(remaining, max burst[, beats left in the 4 KB page])
    always_comb begin
        beats_c = (rem_q < MAX_BEATS) ? rem_q : MAX_BEATS;
`ifdef DMA_CALC_SEQ_4K_SPLIT_EN
        page_bytes_c = PAGE_BITS'(4096) - PAGE_BITS'(addr_q[11:0]);
        page_beats_c = LEN_BITS'(page_bytes_c >> BYTE_SIZE);
        if (page_beats_c < beats_c) begin
            beats_c = page_beats_c;
        end
`endif
    end

    // Outstanding count; a completion with nothing outstanding is flagged instead of wrapping
    always_comb begin
        cnt_nxt_c = cnt;
        err_c     = 1'b0;
        if (fire && !burst_done) begin
            cnt_nxt_c = cnt + CNT_BITS'(1);
        end else if (!fire && burst_done) begin
            if (cnt == '0) begin
                err_c = 1'b1;
            end else begin
                cnt_nxt_c = cnt - CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            rem_q     <= '0;
            beats_q   <= '0;
            cmd_addr  <= '0;
            cmd_len   <= '0;
            cmd_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            cnt <= cnt_nxt_c;
            if (load) begin
                addr_q <= base;
                rem_q  <= len;
            end else if (fire) begin
                cmd_valid <= 1'b0;
                addr_q    <= addr_q + (ADDR_BITS'(beats_q) << BYTE_SIZE);
                rem_q     <= rem_q - beats_q;
            end else if (run && !cmd_valid && !rem_zero_c && (cnt < CNT_BITS'(MAX_ISSUE))) begin
                cmd_valid <= 1'b1;
                cmd_addr  <= addr_q;
                cmd_len   <= BURST_BITS'(beats_c - LEN_BITS'(1));
                beats_q   <= beats_c;
            end
        end
    end
endmodule

module dma_calc_sequencer #(
    parameter int unsigned ADDR_BITS  = 40,
    parameter int unsigned LEN_BITS   = 32,
    parameter int unsigned BURST_BITS = 8,
    parameter int unsigned BYTE_SIZE  = 4,
    parameter int unsigned MAX_ISSUE  = 8,
    localparam int unsigned CNT_BITS  = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_BITS-1:0]  s_job_src,
    input  logic [ADDR_BITS-1:0]  s_job_dst,
    input  logic [LEN_BITS-1:0]   s_job_len,
    input  logic                  s_job_valid,
    output logic                  s_job_ready,
    output logic [ADDR_BITS-1:0]  m_ar_addr,
    output logic [BURST_BITS-1:0] m_ar_len,
    output logic                  m_ar_valid,
    input  logic                  m_ar_ready,
    output logic [ADDR_BITS-1:0]  m_aw_addr,
    output logic [BURST_BITS-1:0] m_aw_len,
    output logic                  m_aw_valid,
    input  logic                  m_aw_ready,
    input  logic                  s_rdone,
    input  logic                  s_bdone,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [CNT_BITS-1:0]   ar_issue_cnt,
    output logic [CNT_BITS-1:0]   aw_issue_cnt
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_FIN} state_t;

    localparam logic [ADDR_BITS-1:0] ALIGN_MASK =
        ~(ADDR_BITS'((64'(1) << BYTE_SIZE) - 64'(1)));

    state_t              state_q;
    state_t              state_d;
    logic                accept;
    logic                run;
    logic                ar_rem_zero_c;
    logic                aw_rem_zero_c;
    logic                ar_err_c;
    logic                aw_err_c;
    logic [CNT_BITS-1:0] ar_cnt_nxt_c;
    logic [CNT_BITS-1:0] aw_cnt_nxt_c;

    assign accept = (state_q == ST_IDLE) && s_job_valid && s_job_ready;
    assign run    = (state_q == ST_RUN);

    dma_calc_side #(
        .ADDR_BITS(ADDR_BITS), .LEN_BITS(LEN_BITS), .BURST_BITS(BURST_BITS),
        .BYTE_SIZE(BYTE_SIZE), .MAX_ISSUE(MAX_ISSUE)
    ) u_ar (
        .clk(aclk), .rst_n(aresetn), .load(accept), .run(run),
        .base(s_job_src & ALIGN_MASK), .len(s_job_len),
        .cmd_ready(m_ar_ready), .burst_done(s_rdone),
        .cmd_addr(m_ar_addr), .cmd_len(m_ar_len), .cmd_valid(m_ar_valid),
        .cnt(ar_issue_cnt), .cnt_nxt_c(ar_cnt_nxt_c),
        .rem_zero_c(ar_rem_zero_c), .err_c(ar_err_c)
    );

    dma_calc_side #(
        .ADDR_BITS(ADDR_BITS), .LEN_BITS(LEN_BITS), .BURST_BITS(BURST_BITS),
        .BYTE_SIZE(BYTE_SIZE), .MAX_ISSUE(MAX_ISSUE)
    ) u_aw (
        .clk(aclk), .rst_n(aresetn), .load(accept), .run(run),
        .base(s_job_dst & ALIGN_MASK), .len(s_job_len),
        .cmd_ready(m_aw_ready), .burst_done(s_bdone),
        .cmd_addr(m_aw_addr), .cmd_len(m_aw_len), .cmd_valid(m_aw_valid),
        .cnt(aw_issue_cnt), .cnt_nxt_c(aw_cnt_nxt_c),
        .rem_zero_c(aw_rem_zero_c), .err_c(aw_err_c)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DRAIN looks at next-cycle counts so done follows the final completion by one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_RUN;
            ST_RUN:   if (ar_rem_zero_c && aw_rem_zero_c) state_d = ST_DRAIN;
            ST_DRAIN: if ((ar_cnt_nxt_c == '0) && (aw_cnt_nxt_c == '0)) state_d = ST_FIN;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_job_ready <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            s_job_ready <= (state_d == ST_IDLE);
            busy        <= (state_d != ST_IDLE);
            done        <= (state_d == ST_FIN);
            err         <= (accept ? 1'b0 : err) | ar_err_c | aw_err_c;
        end
    end
endmodule

// File: tb/tb_dma_calc_sequencer.sv
// Scoreboard bench for dma_calc_sequencer: expected bursts queued by stimulus, popped by a handshake monitor.
module tb_dma_calc_sequencer;
    localparam int unsigned ADDR_BITS  = 40;
    localparam int unsigned LEN_BITS   = 32;
    localparam int unsigned BURST_BITS = 8;
    localparam int unsigned BYTE_SIZE  = 4;
    localparam int unsigned MAX_ISSUE  = 2;

    logic                  aclk = 1'b0;
    logic                  aresetn = 1'b0;
    logic [ADDR_BITS-1:0]  s_job_src = '0;
    logic [ADDR_BITS-1:0]  s_job_dst = '0;
    logic [LEN_BITS-1:0]   s_job_len = '0;
    logic                  s_job_valid = 1'b0;
    logic                  s_job_ready;
    logic [ADDR_BITS-1:0]  m_ar_addr;
    logic [BURST_BITS-1:0] m_ar_len;
    logic                  m_ar_valid;
    logic                  m_ar_ready = 1'b1;
    logic [ADDR_BITS-1:0]  m_aw_addr;
    logic [BURST_BITS-1:0] m_aw_len;
    logic                  m_aw_valid;
    logic                  m_aw_ready = 1'b1;
    logic                  s_rdone = 1'b0;
    logic                  s_bdone = 1'b0;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [7:0]            ar_issue_cnt;
    logic [7:0]            aw_issue_cnt;

    dma_calc_sequencer #(
        .ADDR_BITS(ADDR_BITS), .LEN_BITS(LEN_BITS), .BURST_BITS(BURST_BITS),
        .BYTE_SIZE(BYTE_SIZE), .MAX_ISSUE(MAX_ISSUE)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_job_src(s_job_src), .s_job_dst(s_job_dst), .s_job_len(s_job_len),
        .s_job_valid(s_job_valid), .s_job_ready(s_job_ready),
        .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_aw_addr(m_aw_addr), .m_aw_len(m_aw_len), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
        .s_rdone(s_rdone), .s_bdone(s_bdone),
        .busy(busy), .done(done), .err(err),
        .ar_issue_cnt(ar_issue_cnt), .aw_issue_cnt(aw_issue_cnt)
    );

    always #5 aclk = ~aclk;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int ar_hs     = 0;
    int aw_hs     = 0;
    int done_cnt  = 0;
    logic [47:0] ar_q[$];
    logic [47:0] aw_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic pulse(input logic r, input logic b);
        s_rdone = r;
        s_bdone = b;
        tick();
        s_rdone = 1'b0;
        s_bdone = 1'b0;
    endtask

    task automatic push_ar(input logic [39:0] a, input logic [7:0] l);
        ar_q.push_back({a, l});
    endtask

    task automatic push_aw(input logic [39:0] a, input logic [7:0] l);
        aw_q.push_back({a, l});
    endtask

    task automatic send_job(input logic [39:0] src, input logic [39:0] dst, input logic [31:0] len);
        int n = 0;
        while (!s_job_ready && n < 20) begin
            tick();
            n++;
        end
        if (!s_job_ready) begin
            total_cnt++;
            $display("FAIL job_ready_timeout: s_job_ready=0 after 20 cycles, expected 1");
        end
        s_job_src   = src;
        s_job_dst   = dst;
        s_job_len   = len;
        s_job_valid = 1'b1;
        tick();
        s_job_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk(name, 64'(done), 64'd1);
    endtask

    task automatic finish_job(input string name, input int nr, input int nb);
        int m = (nr > nb) ? nr : nb;
        tick(12);
        for (int i = 0; i < m; i++) pulse(i < nr, i < nb);
        wait_done({name, "_done"}, 20);
        tick();
        chk({name, "_done_single"}, 64'(done), 64'd0);
        chk({name, "_busy_low"}, 64'(busy), 64'd0);
        chk({name, "_ready_back"}, 64'(s_job_ready), 64'd1);
        chk({name, "_err"}, 64'(err), 64'd0);
    endtask

    // Handshake monitor: every accepted command must match the head of its queue
    always @(negedge aclk) begin
        if (aresetn) begin
            if (m_ar_valid && m_ar_ready) begin
                ar_hs++;
                if (ar_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL ar_extra: addr 0x%0h len 0x%0h, expected no burst", m_ar_addr, m_ar_len);
                end else begin
                    chk("ar_burst", 64'({m_ar_addr, m_ar_len}), 64'(ar_q.pop_front()));
                end
            end
            if (m_aw_valid && m_aw_ready) begin
                aw_hs++;
                if (aw_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL aw_extra: addr 0x%0h len 0x%0h, expected no burst", m_aw_addr, m_aw_len);
                end else begin
                    chk("aw_burst", 64'({m_aw_addr, m_aw_len}), 64'(aw_q.pop_front()));
                end
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int early;
        int base;
        int n;
        int nr2;

        // Reset values
        #2;
        chk("rst_ready", 64'(s_job_ready), 64'd0);
        chk("rst_valids", 64'({m_ar_valid, m_aw_valid}), 64'd0);
        chk("rst_flags", 64'({busy, done, err}), 64'd0);
        chk("rst_cnts", 64'({ar_issue_cnt, aw_issue_cnt}), 64'd0);
        chk("rst_addr", 64'({m_ar_addr, m_ar_len, m_aw_addr, m_aw_len}), 64'd0);
        tick(2);
        aresetn = 1'b1;
        tick();
        chk("post_rst_ready", 64'(s_job_ready), 64'd1);

        // Job 1: 300 beats, page-sized first burst; then done timing with a late final bresp
        push_ar(40'h1000, 8'hff); push_ar(40'h2000, 8'h2b);
        push_aw(40'h2000, 8'hff); push_aw(40'h3000, 8'h2b);
        send_job(40'h1000, 40'h2000, 32'd300);
        chk("t1_latch_cycle_valid", 64'({m_ar_valid, m_aw_valid}), 64'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_ready_low", 64'(s_job_ready), 64'd0);
        tick();
        chk("t1_first_valid", 64'({m_ar_valid, m_aw_valid}), 64'h3);
        chk("t1_first_len", 64'(m_ar_len), 64'hff);
        tick(10);
        chk("t1_ar_cnt", 64'(ar_issue_cnt), 64'd2);
        chk("t1_aw_cnt", 64'(aw_issue_cnt), 64'd2);
        pulse(1'b1, 1'b1);
        pulse(1'b1, 1'b0);
        early = 0;
        repeat (50) begin
            tick();
            if (done) early++;
        end
        chk("t4_no_early_done", 64'(early), 64'd0);
        pulse(1'b0, 1'b1);
        chk("t4_done_after_bdone", 64'(done), 64'd1);
        chk("t4_busy_in_fin", 64'(busy), 64'd1);
        tick();
        chk("t4_done_single", 64'(done), 64'd0);
        chk("t4_busy_low", 64'(busy), 64'd0);
        chk("t4_ready_back", 64'(s_job_ready), 64'd1);

        // Job 2: unaligned source near a 4 KB page end
`ifdef DMA_CALC_SEQ_4K_SPLIT_EN
        push_ar(40'h1F00, 8'h0f); push_ar(40'h2000, 8'h0f);
        nr2 = 2;
`else
        push_ar(40'h1F00, 8'h1f);
        nr2 = 1;
`endif
        push_aw(40'h5000, 8'h1f);
        send_job(40'h1F07, 40'h5000, 32'd32);
        finish_job("t2", nr2, 1);

        // Job 3: issue limit of 2 with read completions withheld
        push_ar(40'h0000, 8'hff); push_ar(40'h1000, 8'hff);
        push_ar(40'h2000, 8'hff); push_ar(40'h3000, 8'hff);
        push_aw(40'h10000, 8'hff); push_aw(40'h11000, 8'hff);
        push_aw(40'h12000, 8'hff); push_aw(40'h13000, 8'hff);
        base = ar_hs;
        send_job(40'h0, 40'h10000, 32'd1024);
        tick(12);
        chk("t3_ar_cnt_limit", 64'(ar_issue_cnt), 64'd2);
        chk("t3_ar_issued", 64'(ar_hs - base), 64'd2);
        pulse(1'b1, 1'b0);
        n = 0;
        while ((ar_hs - base) < 3 && n < 3) begin
            tick();
            n++;
        end
        chk("t3_third_ar", 64'(ar_hs - base), 64'd3);
        tick(4);
        repeat (3) begin
            pulse(1'b1, 1'b1);
            tick(4);
        end
        pulse(1'b0, 1'b1);
        wait_done("t3_done", 20);
        tick();
        chk("t3_busy_low", 64'(busy), 64'd0);

        // Completion with nothing outstanding
        pulse(1'b1, 1'b0);
        chk("t5_cnt_stays_0", 64'(ar_issue_cnt), 64'd0);
        chk("t5_err_set", 64'(err), 64'd1);
        tick(3);
        chk("t5_err_sticky", 64'(err), 64'd1);

        // Job 4: abort by reset with 3 bursts outstanding
        push_ar(40'h0000, 8'hff); push_ar(40'h1000, 8'hff);
        push_aw(40'h8000, 8'hff);
        base = aw_hs;
        send_job(40'h0, 40'h8000, 32'd1024);
        chk("t5_err_cleared", 64'(err), 64'd0);
        n = 0;
        while ((aw_hs - base) < 1 && n < 10) begin
            tick();
            n++;
        end
        m_aw_ready = 1'b0;
        tick(6);
        chk("t6_aw_stall_valid", 64'(m_aw_valid), 64'd1);
        chk("t6_aw_stall_addr", 64'(m_aw_addr), 64'h9000);
        tick(3);
        chk("t6_aw_stall_hold", 64'({m_aw_addr, m_aw_len}), 64'({40'h9000, 8'hff}));
        chk("t6_outstanding", 64'({ar_issue_cnt, aw_issue_cnt}), 64'h0201);
        aresetn = 1'b0;
        #1;
        chk("t6_rst_valids", 64'({m_ar_valid, m_aw_valid}), 64'd0);
        chk("t6_rst_flags", 64'({busy, done, err, s_job_ready}), 64'd0);
        chk("t6_rst_cnts", 64'({ar_issue_cnt, aw_issue_cnt}), 64'd0);
        chk("t6_rst_addr", 64'({m_ar_addr, m_ar_len, m_aw_addr, m_aw_len}), 64'd0);
        tick(2);
        aresetn = 1'b1;
        m_aw_ready = 1'b1;
        chk("t6_queues_drained", 64'(ar_q.size() + aw_q.size()), 64'd0);
        tick();
        chk("t6_ready_after_rst", 64'(s_job_ready), 64'd1);
        push_ar(40'h3000, 8'h0f);
        push_aw(40'h4000, 8'h0f);
        send_job(40'h3000, 40'h4000, 32'd16);
        finish_job("t6_new_job", 1, 1);

        chk("end_queues_empty", 64'(ar_q.size() + aw_q.size()), 64'd0);
        chk("end_done_count", 64'(done_cnt), 64'd4);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
